// File: rtl/freq_digit_sequencer_if.sv
// Bus between the frequency-counter core and the digit sequencer.
//   bcd_in    : latched BCD measurement, MSD in the top nibble
//   load      : one-cycle strobe qualifying bcd_in
//   segments  : 7-segment pattern, bit0=a .. bit6=g, active-high
//   busy      : sequencer is cycling a frame
//   digit_idx : index of the digit currently lit, 0 when not lit
interface freq_digit_sequencer_if #(
    parameter int unsigned NDIGITS = 3
);
    localparam int unsigned VAL_W = 4 * NDIGITS;
    localparam int unsigned IDX_W = $clog2(NDIGITS) + 1;

    logic [VAL_W-1:0] bcd_in;
    logic             load;
    logic [6:0]       segments;
    logic             busy;
    logic [IDX_W-1:0] digit_idx;

    modport master (output bcd_in, load, input segments, busy, digit_idx);
    modport slave  (input bcd_in, load, output segments, busy, digit_idx);
endinterface

// File: rtl/freq_digit_sequencer.sv
// Shows a latched multi-digit BCD value one digit at a time on a single
// 7-segment output, with a blank gap after each digit and a longer blank
// marking the end of the frame. Leading zeros are suppressed and nibbles
// A-F show a dash. A value loaded mid-frame is held pending and takes
// effect at the start of the next frame.
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : slave side of freq_digit_sequencer_if (bcd_in/load in,
//         segments/busy/digit_idx out, all outputs registered)
module freq_digit_sequencer #(
    parameter int unsigned NDIGITS      = 3,
    parameter int unsigned DIGIT_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned END_CYCLES   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    freq_digit_sequencer_if.slave bus
);
    localparam int unsigned VAL_W   = 4 * NDIGITS;
    localparam int unsigned IDX_W   = $clog2(NDIGITS) + 1;
    localparam int unsigned MAX_A   = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > END_CYCLES) ? MAX_A : END_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP, ST_END} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VAL_W-1:0] active_q, active_d;
    logic [VAL_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [6:0]       segments_q, segments_d;
    logic             busy_q, busy_d;
    logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
    logic [VAL_W-1:0] frame_val;

    // BCD to 7-segment, g..a; non-decimal nibbles show a dash
    function automatic logic [6:0] seg_encode(input logic [3:0] n);
        case (n)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Highest non-zero nibble; digit 0 when the whole value is zero
    function automatic logic [IDX_W-1:0] first_digit(input logic [VAL_W-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(NDIGITS); i++) begin
            if (v[4*i +: 4] != 4'h0) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [3:0] nibble(input logic [VAL_W-1:0] v, input logic [IDX_W-1:0] i);
        logic [VAL_W-1:0] sh;
        sh = v >> (4 * int'(i));
        return sh[3:0];
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            active_q    <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            segments_q  <= '0;
            busy_q      <= 1'b0;
            digit_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            segments_q  <= segments_d;
            busy_q      <= busy_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    // Next-state, counter, value registers and registered output values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        frame_val   = active_q;

        // Loads while busy are parked; the last one before the frame ends wins
        if (bus.load && state_q != ST_IDLE) begin
            pend_d     = bus.bcd_in;
            pend_vld_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    active_d = bus.bcd_in;
                    idx_d    = first_digit(bus.bcd_in);
                    cnt_d    = CNT_W'(DIGIT_CYCLES - 1);
                    state_d  = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    if (idx_q == '0) begin
                        cnt_d   = CNT_W'(END_CYCLES - 1);
                        state_d = ST_END;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        cnt_d   = CNT_W'(DIGIT_CYCLES - 1);
                        state_d = ST_SHOW;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_END: begin
                if (cnt_q == '0) begin
                    // A load on this very cycle beats an older pending value
                    if (bus.load)        frame_val = bus.bcd_in;
                    else if (pend_vld_q) frame_val = pend_q;
                    active_d   = frame_val;
                    pend_vld_d = 1'b0;
                    idx_d      = first_digit(frame_val);
                    cnt_d      = CNT_W'(DIGIT_CYCLES - 1);
                    state_d    = ST_SHOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        segments_d  = (state_d == ST_SHOW) ? seg_encode(nibble(active_d, idx_d)) : 7'h00;
        digit_idx_d = (state_d == ST_SHOW) ? idx_d : '0;
        busy_d      = (state_d != ST_IDLE);
    end

    assign bus.segments  = segments_q;
    assign bus.busy      = busy_q;
    assign bus.digit_idx = digit_idx_q;
endmodule

// File: tb/tb_freq_digit_sequencer.sv
// Directed bench for freq_digit_sequencer at default parameters.
// Expected segment/index streams are built from hand-coded per-digit
// patterns and the fixed 4/2/6 cycle timing.
module tb_freq_digit_sequencer;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    freq_digit_sequencer_if #(.NDIGITS(3)) bus ();

    freq_digit_sequencer #(
        .NDIGITS(3), .DIGIT_CYCLES(4), .GAP_CYCLES(2), .END_CYCLES(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]     bcd;
        int              ndig;
        logic [2:0][6:0] segs;  // segs[0] is the first digit shown
    } vec_t;

    vec_t       vecs[7];
    logic [6:0] exp_seg[$];
    logic [2:0] exp_idx[$];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge; loads are single-cycle strobes
    task automatic tick();
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    task automatic push(input logic [6:0] s, input logic [2:0] i);
        exp_seg.push_back(s);
        exp_idx.push_back(i);
    endtask

    task automatic push_frame(input logic [2:0][6:0] segs, input int ndig);
        for (int k = 0; k < ndig; k++) begin
            for (int c = 0; c < 4; c++) push(segs[k], 3'(ndig - 1 - k));
            for (int c = 0; c < 2; c++) push(7'h00, 3'd0);
        end
        for (int c = 0; c < 6; c++) push(7'h00, 3'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Walks the expected stream; the caller has already driven the first load.
    // Extra loads are driven after sampling cycle at1/at2 (-1 disables).
    task automatic run_stream(input string name, input int at1, input logic [11:0] v1,
                              input int at2, input logic [11:0] v2);
        for (int c = 0; c < exp_seg.size(); c++) begin
            if (c == at1) begin bus.bcd_in = v1; bus.load = 1'b1; end
            if (c == at2) begin bus.bcd_in = v2; bus.load = 1'b1; end
            tick();
            check($sformatf("%s seg c%0d", name, c + 1), 8'(bus.segments), 8'(exp_seg[c]));
            check($sformatf("%s idx c%0d", name, c + 1), 8'(bus.digit_idx), 8'(exp_idx[c]));
            check($sformatf("%s busy c%0d", name, c + 1), 8'(bus.busy), 8'h01);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        vecs[0] = '{bcd: 12'h123, ndig: 3, segs: {7'h4F, 7'h5B, 7'h06}};
        vecs[1] = '{bcd: 12'h007, ndig: 1, segs: {7'h00, 7'h00, 7'h07}};
        vecs[2] = '{bcd: 12'h000, ndig: 1, segs: {7'h00, 7'h00, 7'h3F}};
        vecs[3] = '{bcd: 12'h100, ndig: 3, segs: {7'h3F, 7'h3F, 7'h06}};
        vecs[4] = '{bcd: 12'h0A5, ndig: 2, segs: {7'h00, 7'h6D, 7'h40}};
        vecs[5] = '{bcd: 12'h9F0, ndig: 3, segs: {7'h3F, 7'h40, 7'h6F}};
        vecs[6] = '{bcd: 12'h080, ndig: 2, segs: {7'h00, 7'h3F, 7'h7F}};

        // Reset with no clock edge, then idle without load
        rst        = 1'b0;
        bus.load   = 1'b0;
        bus.bcd_in = '0;
        #1 rst = 1'b1;
        #1;
        check("reset seg", 8'(bus.segments), 8'h00);
        check("reset busy", 8'(bus.busy), 8'h00);
        check("reset idx", 8'(bus.digit_idx), 8'h00);
        #2 rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            check($sformatf("idle seg c%0d", c), 8'(bus.segments), 8'h00);
            check($sformatf("idle busy c%0d", c), 8'(bus.busy), 8'h00);
        end

        // Table: one full frame from IDLE plus the first cycle of the repeat
        for (int v = 0; v < 7; v++) begin
            do_reset();
            exp_seg.delete();
            exp_idx.delete();
            push_frame(vecs[v].segs, vecs[v].ndig);
            push(vecs[v].segs[0], 3'(vecs[v].ndig - 1));
            bus.bcd_in = vecs[v].bcd;
            bus.load   = 1'b1;
            run_stream($sformatf("vec%0d %h", v, vecs[v].bcd), -1, 12'h0, -1, 12'h0);
        end

        // Loads during "2" of 0x123: 0x456 then 0x789; only 0x789 follows
        do_reset();
        exp_seg.delete();
        exp_idx.delete();
        push_frame(vecs[0].segs, 3);
        push_frame({7'h6F, 7'h7F, 7'h07}, 3);
        push(7'h07, 3'd2);
        bus.bcd_in = 12'h123;
        bus.load   = 1'b1;
        run_stream("midload", 7, 12'h456, 10, 12'h789);

        // Loads in the last two END cycles; the final-cycle load starts the next frame
        do_reset();
        exp_seg.delete();
        exp_idx.delete();
        push_frame(vecs[1].segs, 1);
        push_frame({7'h00, 7'h3F, 7'h6D}, 2);
        push(7'h6D, 3'd1);
        bus.bcd_in = 12'h007;
        bus.load   = 1'b1;
        run_stream("endload", 11, 12'h999, 12, 12'h050);

        // Async reset while "3" of 0x123 is lit
        do_reset();
        exp_seg.delete();
        exp_idx.delete();
        push_frame(vecs[0].segs, 3);
        while (exp_seg.size() > 14) begin
            void'(exp_seg.pop_back());
            void'(exp_idx.pop_back());
        end
        bus.bcd_in = 12'h123;
        bus.load   = 1'b1;
        run_stream("pre-rst", -1, 12'h0, -1, 12'h0);
        #2 rst = 1'b1;
        #1;
        check("async rst seg", 8'(bus.segments), 8'h00);
        check("async rst busy", 8'(bus.busy), 8'h00);
        check("async rst idx", 8'(bus.digit_idx), 8'h00);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            check($sformatf("post-rst seg c%0d", c), 8'(bus.segments), 8'h00);
            check($sformatf("post-rst busy c%0d", c), 8'(bus.busy), 8'h00);
        end
        exp_seg.delete();
        exp_idx.delete();
        push_frame(vecs[1].segs, 1);
        bus.bcd_in = 12'h007;
        bus.load   = 1'b1;
        run_stream("post-rst load", -1, 12'h0, -1, 12'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
